axi4_lite_rgb_pwm: RTL and testbench

//  AXI4-Lite slave on the CPU port (axi4_cpu) that drives the two on-board RGB LEDs
//  (RGB1, RGB2) with 8-bit PWM per colour channel, under software control.

---
 rtl/axi4_lite_rgb_pwm.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_rgb_pwm.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_rgb_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_rgb_pwm
//  Purpose  : AXI4-Lite slave on the CPU port that drives the two on-board
//             RGB LEDs with an 8-bit PWM per colour channel.
//             Duty values are double-buffered: software writes land in
//             DUTY1/DUTY2 and are copied into shadow duties only when the
//             PWM counter wraps 255 -> 0, so a pulse never changes width
//             mid-frame. The LED outputs are registered (glitch-free).
//
//  Ports    : aclk          clock, rising edge
//             aresetn       synchronous reset, active-low
//             i_aw*/o_aw*   AXI4-Lite write address channel
//             i_w*/o_w*     AXI4-Lite write data channel
//             o_b*/i_b*     AXI4-Lite write response channel
//             i_ar*/o_ar*   AXI4-Lite read address channel
//             o_r*/i_r*     AXI4-Lite read data channel
//             rgb1, rgb2    {B,G,R} LED drives, active-high
//
//  Register map (byte offsets, addr[1:0] ignored, upper bits fully decoded)
//             0x00 CTRL     [0] enable, [1] heartbeat
//             0x04 DUTY1    [7:0] R, [15:8] G, [23:16] B
//             0x08 DUTY2    same layout as DUTY1
//             0x0C PRESCALE [15:0]
//             0x10 ID       read-only 32'h5247_4201
//             other         SLVERR, reads return 0, writes discarded
//
//  Revision : 1.0  initial release
// ============================================================================
module axi4_lite_rgb_pwm #(
    parameter int          A            = 16,      // address width
    parameter int          N            = 4,       // data bytes, only 4 supported
    parameter logic [15:0] PRESCALE_RST = 16'd390  // reset value of PRESCALE
) (
    input  wire logic             aclk,
    input  wire logic             aresetn,

    // write address channel
    input  wire logic [A-1:0]     i_awaddr,
    input  wire logic             i_awvalid,
    output logic                  o_awready,

    // write data channel
    input  wire logic [8*N-1:0]   i_wdata,
    input  wire logic [N-1:0]     i_wstrb,
    input  wire logic             i_wvalid,
    output logic                  o_wready,

    // write response channel
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  wire logic             i_bready,

    // read address channel
    input  wire logic [A-1:0]     i_araddr,
    input  wire logic             i_arvalid,
    output logic                  o_arready,

    // read data channel
    output logic [8*N-1:0]        o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rvalid,
    input  wire logic             i_rready,

    // LED drives {B,G,R}
    output logic [2:0]            rgb1,
    output logic [2:0]            rgb2
);

    localparam int          c_DW          = 8 * N;
    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;
    localparam logic [31:0] c_ID_VALUE    = 32'h5247_4201;

    // Word indices (address bits [A-1:2])
    localparam logic [A-3:0] c_IDX_CTRL     = (A-2)'(0);
    localparam logic [A-3:0] c_IDX_DUTY1    = (A-2)'(1);
    localparam logic [A-3:0] c_IDX_DUTY2    = (A-2)'(2);
    localparam logic [A-3:0] c_IDX_PRESCALE = (A-2)'(3);
    localparam logic [A-3:0] c_IDX_ID       = (A-2)'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // r_live is 0 in the cycle right after reset so that every READY
    // output is low while the block is (or has just been) in reset.
    logic             r_live;

    logic             r_aw_held;
    logic [A-3:0]     r_aw_idx;
    logic             r_w_held;
    logic [c_DW-1:0]  r_wdata;
    logic [N-1:0]     r_wstrb;
    logic             r_bvalid;
    logic [1:0]       r_bresp;

    logic             r_rvalid;
    logic [c_DW-1:0]  r_rdata;
    logic [1:0]       r_rresp;

    logic             r_enable;
    logic             r_heartbeat;
    logic [23:0]      r_duty1;
    logic [23:0]      r_duty2;
    logic [15:0]      r_prescale;

    logic [23:0]      r_shadow1;
    logic [23:0]      r_shadow2;
    logic [15:0]      r_presc_cnt;
    logic [7:0]       r_pwm_cnt;
    logic [2:0]       r_rgb1;
    logic [2:0]       r_rgb2;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic             w_do_write;
    logic [c_DW-1:0]  w_wmask;
    logic [c_DW-1:0]  w_wr_cur;
    logic [c_DW-1:0]  w_wr_new;
    logic [1:0]       w_wr_resp;
    logic [c_DW-1:0]  w_rd_data;
    logic [1:0]       w_rd_resp;
    logic             w_tick;
    logic             w_frame_end;
    logic [2:0]       w_rgb1_nxt;
    logic [2:0]       w_rgb2_nxt;

    assign o_awready = r_live & ~r_aw_held & ~r_bvalid;
    assign o_wready  = r_live & ~r_w_held  & ~r_bvalid;
    assign o_arready = r_live & ~r_rvalid;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign rgb1      = r_rgb1;
    assign rgb2      = r_rgb2;

    // Both halves of the write are held: commit on the next edge.
    assign w_do_write = r_aw_held & r_w_held & ~r_bvalid;

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < N; b++) begin
            w_wmask[8*b +: 8] = {8{r_wstrb[b]}};
        end
    end

    // Current contents of the write target, merged with the strobed data.
    always_comb begin
        w_wr_cur  = '0;
        w_wr_resp = c_RESP_OKAY;
        case (r_aw_idx)
            c_IDX_CTRL:     w_wr_cur = c_DW'({r_heartbeat, r_enable});
            c_IDX_DUTY1:    w_wr_cur = c_DW'(r_duty1);
            c_IDX_DUTY2:    w_wr_cur = c_DW'(r_duty2);
            c_IDX_PRESCALE: w_wr_cur = c_DW'(r_prescale);
            c_IDX_ID:       w_wr_cur = c_DW'(c_ID_VALUE);
            default:        w_wr_resp = c_RESP_SLVERR;
        endcase
    end

    assign w_wr_new = (w_wr_cur & ~w_wmask) | (r_wdata & w_wmask);

    // Read mux on the live AR address; captured when AR is accepted.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_RESP_OKAY;
        case (i_araddr[A-1:2])
            c_IDX_CTRL:     w_rd_data = c_DW'({r_heartbeat, r_enable});
            c_IDX_DUTY1:    w_rd_data = c_DW'(r_duty1);
            c_IDX_DUTY2:    w_rd_data = c_DW'(r_duty2);
            c_IDX_PRESCALE: w_rd_data = c_DW'(r_prescale);
            c_IDX_ID:       w_rd_data = c_DW'(c_ID_VALUE);
            default:        w_rd_resp = c_RESP_SLVERR;
        endcase
    end

    // ">=" rather than "==" so that lowering PRESCALE below the running
    // count wraps on the next cycle instead of running to 65535.
    assign w_tick      = (r_presc_cnt >= r_prescale);
    assign w_frame_end = w_tick & (r_pwm_cnt == 8'hFF);

    always_comb begin
        w_rgb1_nxt[0] = r_enable & (r_pwm_cnt < r_shadow1[7:0]);
        w_rgb1_nxt[1] = r_heartbeat ? r_pwm_cnt[7]
                                    : (r_enable & (r_pwm_cnt < r_shadow1[15:8]));
        w_rgb1_nxt[2] = r_enable & (r_pwm_cnt < r_shadow1[23:16]);
        w_rgb2_nxt[0] = r_enable & (r_pwm_cnt < r_shadow2[7:0]);
        w_rgb2_nxt[1] = r_enable & (r_pwm_cnt < r_shadow2[15:8]);
        w_rgb2_nxt[2] = r_enable & (r_pwm_cnt < r_shadow2[23:16]);
    end

    // Address low bits and the upper bits of the merged word carry no state.
    logic w_unused;
    assign w_unused = &{1'b0, i_awaddr[1:0], i_araddr[1:0], w_wr_new[c_DW-1:24]};

    // ------------------------------------------------------------------
    // Write channel handshakes
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            r_live <= 1'b1;
            if (i_awvalid && o_awready) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= i_awaddr[A-1:2];
            end
            if (i_wvalid && o_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
            if (w_do_write) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else if (r_bvalid && i_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_enable    <= 1'b0;
            r_heartbeat <= 1'b0;
            r_duty1     <= '0;
            r_duty2     <= '0;
            r_prescale  <= PRESCALE_RST;
        end else if (w_do_write) begin
            case (r_aw_idx)
                c_IDX_CTRL:     {r_heartbeat, r_enable} <= w_wr_new[1:0];
                c_IDX_DUTY1:    r_duty1    <= w_wr_new[23:0];
                c_IDX_DUTY2:    r_duty2    <= w_wr_new[23:0];
                c_IDX_PRESCALE: r_prescale <= w_wr_new[15:0];
                default:        ;  // ID and unmapped: nothing to store
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else if (i_arvalid && o_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // PWM engine
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
            r_shadow1   <= '0;
            r_shadow2   <= '0;
            r_rgb1      <= '0;
            r_rgb2      <= '0;
        end else begin
            if (w_tick) begin
                r_presc_cnt <= '0;
                r_pwm_cnt   <= r_pwm_cnt + 8'd1;
            end else begin
                r_presc_cnt <= r_presc_cnt + 16'd1;
            end
            // Frame boundary: new duties apply from pwm_cnt == 0 onwards.
            if (w_frame_end) begin
                r_shadow1 <= r_duty1;
                r_shadow2 <= r_duty2;
            end
            r_rgb1 <= w_rgb1_nxt;
            r_rgb2 <= w_rgb2_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_rgb_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_rgb_pwm
//  Purpose  : Self-checking bench for axi4_lite_rgb_pwm. A register-level
//             reference model predicts every AXI response; expected
//             responses are queued when a transaction is issued and popped
//             by a monitor when the DUT completes the handshake. PWM output
//             is checked by counting high cycles per 256-cycle frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_rgb_pwm;

    localparam int A = 16;
    localparam int N = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [15:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [2:0]  rgb1;
    logic [2:0]  rgb2;

    axi4_lite_rgb_pwm #(.A(A), .N(N), .PRESCALE_RST(16'd390)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid), .o_wready(wready),
        .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
        .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready),
        .rgb1(rgb1), .rgb2(rgb2)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { logic [15:0] a; logic [31:0] d; logic [1:0] r; } rexp_t;
    typedef struct { logic [15:0] a; logic [1:0] r; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];

    // Reference register contents, stored already masked to their fields.
    logic [31:0] m_ctrl, m_duty1, m_duty2, m_presc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic model_reset();
        m_ctrl  = 32'd0;
        m_duty1 = 32'd0;
        m_duty2 = 32'd0;
        m_presc = 32'd390;
    endtask

    task automatic model_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        d = 32'd0;
        case (a & 16'hFFFC)
            16'h0000: d = m_ctrl;
            16'h0004: d = m_duty1;
            16'h0008: d = m_duty2;
            16'h000C: d = m_presc;
            16'h0010: d = 32'h5247_4201;
            default:  r = 2'b10;
        endcase
    endtask

    task automatic model_write(input logic [15:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] r);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
        r = 2'b00;
        case (a & 16'hFFFC)
            16'h0000: m_ctrl  = ((m_ctrl  & ~mask) | (d & mask)) & 32'h0000_0003;
            16'h0004: m_duty1 = ((m_duty1 & ~mask) | (d & mask)) & 32'h00FF_FFFF;
            16'h0008: m_duty2 = ((m_duty2 & ~mask) | (d & mask)) & 32'h00FF_FFFF;
            16'h000C: m_presc = ((m_presc & ~mask) | (d & mask)) & 32'h0000_FFFF;
            16'h0010: ;
            default:  r = 2'b10;
        endcase
    endtask

    // ---------------- monitor ----------------
    always @(negedge aclk) begin
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                timeout("r_unexpected_response");
            end else begin
                rexp_t e;
                e = rq.pop_front();
                check($sformatf("rdata@%04h", e.a), rdata, e.d);
                check($sformatf("rresp@%04h", e.a), 32'(rresp), 32'(e.r));
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                timeout("b_unexpected_response");
            end else begin
                bexp_t e;
                e = bq.pop_front();
                check($sformatf("bresp@%04h", e.a), 32'(bresp), 32'(e.r));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_at, input int w_at, input int bdelay);
        logic [1:0] r;
        logic aw_done, w_done, aw_fire, w_fire;
        int cyc, k;
        bexp_t e;
        model_write(a, d, s, r);
        e.a = a; e.r = r;
        bq.push_back(e);
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        @(posedge aclk); #1;
        while (!(aw_done && w_done) && cyc < 200) begin
            if (!aw_done && cyc >= aw_at) begin awvalid = 1'b1; awaddr = a; end
            if (!w_done && cyc >= w_at) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            @(negedge aclk);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            cyc++;
        end
        if (!(aw_done && w_done)) timeout("aw_w_accept");
        k = 0;
        while (!bvalid && k < 50) begin @(posedge aclk); #1; k++; end
        if (!bvalid) timeout("bvalid_rise");
        for (int i = 0; i < bdelay; i++) begin
            @(negedge aclk);
            check("bvalid_held", 32'(bvalid), 32'd1);
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!bvalid && k < 50) begin @(negedge aclk); k++; end
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, input int rdelay);
        rexp_t e;
        int k;
        logic fire;
        e.a = a;
        model_read(a, e.d, e.r);
        rq.push_back(e);
        @(posedge aclk); #1;
        arvalid = 1'b1; araddr = a;
        k = 0; fire = 1'b0;
        while (!fire && k < 200) begin
            @(negedge aclk);
            fire = arready;
            @(posedge aclk); #1;
            k++;
        end
        arvalid = 1'b0;
        if (!fire) timeout("ar_accept");
        for (int i = 0; i < rdelay; i++) begin
            @(negedge aclk);
            check("rvalid_held", 32'(rvalid), 32'd1);
            @(posedge aclk); #1;
        end
        rready = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!rvalid && k < 50) begin @(negedge aclk); k++; end
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd0);
        check({tag, "_wready"},  32'(wready),  32'd0);
        check({tag, "_arready"}, 32'(arready), 32'd0);
        check({tag, "_bvalid"},  32'(bvalid),  32'd0);
        check({tag, "_rvalid"},  32'(rvalid),  32'd0);
        check({tag, "_rgb"},     32'({rgb2, rgb1}), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int hi_r[3];
        int hi_other[3];
        int hb_g, hb_rest, k;
        logic prev, found;
        logic [31:0] old_d;
        logic [1:0]  old_r, wr_r;
        logic [15:0] a;
        rexp_t re;
        bexp_t be;

        model_reset();
        repeat (4) @(posedge aclk);
        #1;
        check_idle_reset("in_reset");
        aresetn = 1'b1;

        // Reset values
        axi_read(16'h0000, 0);
        axi_read(16'h0004, 0);
        axi_read(16'h000C, 0);
        axi_read(16'h0010, 0);
        check("rgb_after_reset", 32'({rgb2, rgb1}), 32'd0);

        // AW leading W, W leading AW, slow BREADY, byte strobes
        axi_write(16'h0004, 32'hFFFF_FFFF, 4'b0010, 0, 3, 5);
        axi_read(16'h0004, 2);
        axi_write(16'h0008, 32'h0012_3456, 4'b1111, 3, 0, 5);
        axi_read(16'h0008, 0);
        axi_write(16'h0010, 32'hDEAD_BEEF, 4'b1111, 0, 0, 1);
        axi_read(16'h0010, 0);

        // Unmapped offsets
        axi_write(16'h0014, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0);
        axi_write(16'hFFFC, 32'hFFFF_FFFF, 4'b1111, 1, 0, 0);
        axi_read(16'h0014, 0);
        axi_read(16'hFFFC, 0);
        for (int i = 0; i < 5; i++) axi_read(16'(4 * i), 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: a = 16'h0000;
                1: a = 16'h0004;
                2: a = 16'h0008;
                3: a = 16'h000C;
                4: a = 16'h0010;
                5: a = 16'h0014;
                6: a = 16'hFFFC;
                default: a = 16'($urandom_range(0, 65535));
            endcase
            a = a | 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
            else
                axi_read(a, $urandom_range(0, 4));
        end

        // Read accepted on the same edge that commits a write: old value returned
        re.a = 16'h0008;
        model_read(16'h0008, old_d, old_r);
        re.d = old_d; re.r = old_r;
        rq.push_back(re);
        model_write(16'h0008, 32'h00A5_5A5A, 4'b1111, wr_r);
        be.a = 16'h0008; be.r = wr_r;
        bq.push_back(be);
        @(posedge aclk); #1;
        awvalid = 1'b1; awaddr = 16'h0008;
        wvalid = 1'b1; wdata = 32'h00A5_5A5A; wstrb = 4'b1111;
        @(negedge aclk);
        check("same_cycle_aw_w_ready", 32'({awready, wready}), 32'd3);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 16'h0008;
        @(negedge aclk);
        check("same_cycle_arready", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!(rvalid && bvalid) && k < 20) begin @(negedge aclk); k++; end
        @(posedge aclk); #1;
        rready = 1'b0; bready = 1'b0;
        axi_read(16'h0008, 0);

        // PWM: 64/256 on R1, then a mid-frame change to 128
        axi_write(16'h000C, 32'd0, 4'b1111, 0, 0, 0);
        axi_write(16'h0008, 32'd0, 4'b1111, 0, 0, 0);
        axi_write(16'h0004, 32'h40, 4'b1111, 0, 0, 0);
        axi_write(16'h0000, 32'd1, 4'b1111, 0, 0, 0);
        repeat (300) @(posedge aclk);
        prev = 1'b1; found = 1'b0; k = 0;
        while (!found && k < 1000) begin
            @(negedge aclk);
            if (!prev && rgb1[0]) found = 1'b1;
            prev = rgb1[0];
            k++;
        end
        if (!found) timeout("r1_frame_start");
        for (int f = 0; f < 3; f++) begin hi_r[f] = 0; hi_other[f] = 0; end
        fork
            begin
                for (int s = 0; s < 768; s++) begin
                    if (s != 0) @(negedge aclk);
                    hi_r[s / 256]     += int'(rgb1[0]);
                    hi_other[s / 256] += int'(rgb1[1]) + int'(rgb1[2]) + int'(rgb2[0])
                                       + int'(rgb2[1]) + int'(rgb2[2]);
                end
            end
            begin
                repeat (256 + 30) @(posedge aclk);
                axi_write(16'h0004, 32'h80, 4'b1111, 0, 0, 0);
            end
        join
        check("r1_high_frame0", 32'(hi_r[0]), 32'd64);
        check("r1_high_frame1_midwrite", 32'(hi_r[1]), 32'd64);
        check("r1_high_frame2", 32'(hi_r[2]), 32'd128);
        for (int f = 0; f < 3; f++)
            check($sformatf("other_leds_frame%0d", f), 32'(hi_other[f]), 32'd0);

        // Heartbeat with enable cleared: G1 follows pwm_cnt[7], the rest off
        axi_write(16'h0000, 32'd2, 4'b1111, 0, 0, 0);
        repeat (3) @(posedge aclk);
        hb_g = 0; hb_rest = 0;
        for (int s = 0; s < 256; s++) begin
            @(negedge aclk);
            hb_g    += int'(rgb1[1]);
            hb_rest += int'(rgb1[0]) + int'(rgb1[2]) + int'(rgb2[0])
                     + int'(rgb2[1]) + int'(rgb2[2]);
        end
        check("heartbeat_g1_high", 32'(hb_g), 32'd128);
        check("heartbeat_others_off", 32'(hb_rest), 32'd0);

        // Reset while a read response is pending and the PWM is running
        axi_write(16'h0000, 32'd1, 4'b1111, 0, 0, 0);
        axi_write(16'h0008, 32'h00FF_FFFF, 4'b1111, 0, 0, 0);
        repeat (260) @(posedge aclk);
        #1;
        arvalid = 1'b1; araddr = 16'h0010;
        @(negedge aclk);
        check("pre_reset_arready", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("pre_reset_rvalid", 32'(rvalid), 32'd1);
        check("pre_reset_rgb2_on", 32'(rgb2), 32'd7);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        check_idle_reset("after_reset");
        model_reset();
        repeat (20) @(posedge aclk);
        #1;
        check("rgb_off_after_reset", 32'({rgb2, rgb1}), 32'd0);
        for (int i = 0; i < 5; i++) axi_read(16'(4 * i), 0);

        repeat (5) @(posedge aclk);
        check("r_queue_drained", 32'(rq.size()), 32'd0);
        check("b_queue_drained", 32'(bq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
